// File: rtl/clap_event_counter.sv
// Clap event counter: refractory hold-off, single/double classification,
// total/single/double tallies with optional saturation.
//
// Ports: clk_i, rst_i (async, active-high), clap_i (level from detector),
// en_i (accept edges), clr_i (sync clear), total_o/single_o/double_o
// counters, single_evt_o/double_evt_o one-cycle pulses, busy_o (not IDLE).
module clap_event_counter #(
  parameter int CNT_W    = 32,
  parameter int HOLDOFF  = 5000000,
  parameter int WINDOW   = 50000000,
  parameter int SATURATE = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clap_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] total_o,
  output logic [CNT_W-1:0] single_o,
  output logic [CNT_W-1:0] double_o,
  output logic             single_evt_o,
  output logic             double_evt_o,
  output logic             busy_o
);

  localparam int MAXT = (HOLDOFF > WINDOW) ? HOLDOFF : WINDOW;
  localparam int TW   = $clog2(MAXT + 1);

  localparam logic [TW-1:0] HOLD_LD = TW'(HOLDOFF - 1);
  localparam logic [TW-1:0] WIN_LD  = TW'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOCK1,
    WAIT2,
    LOCK2
  } state_t;

  state_t        state_q, state_n;
  logic [TW-1:0] timer_q, timer_n;
  logic          clap_prev;
  logic          acc;
  logic          inc_tot, inc_sgl, inc_dbl;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if ((SATURATE != 0) && (&v)) return v;
    return v + 1'b1;
  endfunction

  assign acc = clap_i & ~clap_prev & en_i;

  always_comb begin
    state_n = state_q;
    timer_n = timer_q;
    inc_tot = 1'b0;
    inc_sgl = 1'b0;
    inc_dbl = 1'b0;
    if (clr_i) begin
      state_n = IDLE;
      timer_n = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            inc_tot = 1'b1;
            timer_n = HOLD_LD;
            state_n = LOCK1;
          end
        end
        LOCK1: begin
          if (timer_q == '0) begin
            timer_n = WIN_LD;
            state_n = WAIT2;
          end else begin
            timer_n = timer_q - 1'b1;
          end
        end
        WAIT2: begin
          // a clap on the final window cycle still beats the timeout
          if (acc) begin
            inc_tot = 1'b1;
            inc_dbl = 1'b1;
            timer_n = HOLD_LD;
            state_n = LOCK2;
          end else if (timer_q == '0) begin
            inc_sgl = 1'b1;
            state_n = IDLE;
          end else begin
            timer_n = timer_q - 1'b1;
          end
        end
        LOCK2: begin
          if (timer_q == '0) begin
            state_n = IDLE;
          end else begin
            timer_n = timer_q - 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          timer_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      clap_prev    <= 1'b0;
      total_o      <= '0;
      single_o     <= '0;
      double_o     <= '0;
      single_evt_o <= 1'b0;
      double_evt_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      // sampled even during clear so a held clap is not recounted
      clap_prev    <= clap_i;
      state_q      <= state_n;
      timer_q      <= timer_n;
      busy_o       <= (state_n != IDLE);
      single_evt_o <= inc_sgl;
      double_evt_o <= inc_dbl;
      if (clr_i) begin
        total_o  <= '0;
        single_o <= '0;
        double_o <= '0;
      end else begin
        if (inc_tot) total_o  <= bump(total_o);
        if (inc_sgl) single_o <= bump(single_o);
        if (inc_dbl) double_o <= bump(double_o);
      end
    end
  end

endmodule

// File: tb/tb_clap_event_counter.sv
// Bench for clap_event_counter: directed scenarios plus random claps,
// checked every cycle against a time-based event model (wrap and saturate).
module tb_clap_event_counter;

  localparam int W  = 4;
  localparam int HO = 4;
  localparam int WI = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clap = 1'b0;
  logic en = 1'b1;
  logic clr = 1'b0;

  logic [W-1:0] tot0, sgl0, dbl0, tot1, sgl1, dbl1;
  logic         sp0, dp0, bz0, sp1, dp1, bz1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clap_event_counter #(
    .CNT_W(W), .HOLDOFF(HO), .WINDOW(WI), .SATURATE(0)
  ) u_wrap (
    .clk_i(clk), .rst_i(rst), .clap_i(clap), .en_i(en), .clr_i(clr),
    .total_o(tot0), .single_o(sgl0), .double_o(dbl0),
    .single_evt_o(sp0), .double_evt_o(dp0), .busy_o(bz0)
  );

  clap_event_counter #(
    .CNT_W(W), .HOLDOFF(HO), .WINDOW(WI), .SATURATE(1)
  ) u_sat (
    .clk_i(clk), .rst_i(rst), .clap_i(clap), .en_i(en), .clr_i(clr),
    .total_o(tot1), .single_o(sgl1), .double_o(dbl1),
    .single_evt_o(sp1), .double_evt_o(dp1), .busy_o(bz1)
  );

  // reference model: event timing by absolute cycle numbers
  int n = 0;
  int mode = 0;
  int s_t = 0;
  int e_t = 0;
  bit m_prev = 0;
  int m_tot = 0, m_sgl = 0, m_dbl = 0;
  bit m_sp = 0, m_dp = 0;
  int sp_seen = 0, dp_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               tag, obs, exp, n);
    end
  endtask

  function automatic int ev(input int c, input bit sat);
    if (sat) return (c > 15) ? 15 : c;
    return c % 16;
  endfunction

  task automatic m_reset();
    mode = 0; m_prev = 0;
    m_tot = 0; m_sgl = 0; m_dbl = 0;
    m_sp = 0; m_dp = 0;
  endtask

  task automatic m_step(input bit c, input bit e, input bit r);
    bit acc;
    acc = c && !m_prev && e;
    m_prev = c;
    m_sp = 0;
    m_dp = 0;
    if (r) begin
      m_tot = 0; m_sgl = 0; m_dbl = 0; mode = 0;
    end else if (mode == 0) begin
      if (acc) begin
        m_tot++; mode = 1; s_t = n;
      end
    end else if (mode == 1) begin
      if (n > s_t + HO) begin
        if (acc) begin
          m_tot++; m_dbl++; m_dp = 1;
          mode = 2; e_t = n + HO;
        end else if (n == s_t + HO + WI) begin
          m_sgl++; m_sp = 1; mode = 0;
        end
      end
    end else begin
      if (n == e_t) mode = 0;
    end
  endtask

  task automatic cmp_all();
    chk("tot_w", 32'(tot0), 32'(ev(m_tot, 0)));
    chk("sgl_w", 32'(sgl0), 32'(ev(m_sgl, 0)));
    chk("dbl_w", 32'(dbl0), 32'(ev(m_dbl, 0)));
    chk("sp_w", 32'(sp0), 32'(m_sp));
    chk("dp_w", 32'(dp0), 32'(m_dp));
    chk("busy_w", 32'(bz0), 32'(mode != 0));
    chk("tot_s", 32'(tot1), 32'(ev(m_tot, 1)));
    chk("sgl_s", 32'(sgl1), 32'(ev(m_sgl, 1)));
    chk("dbl_s", 32'(dbl1), 32'(ev(m_dbl, 1)));
    chk("sp_s", 32'(sp1), 32'(m_sp));
    chk("dp_s", 32'(dp1), 32'(m_dp));
    chk("busy_s", 32'(bz1), 32'(mode != 0));
  endtask

  task automatic step(input bit c, input bit e, input bit r);
    clap = c; en = e; clr = r;
    @(posedge clk);
    n++;
    m_step(c, e, r);
    #1;
    if (sp0) sp_seen++;
    if (dp0) dp_seen++;
    cmp_all();
  endtask

  task automatic quiet(input int k);
    for (int i = 0; i < k; i++) step(0, 1, 0);
  endtask

  task automatic clear();
    step(0, 1, 1);
    sp_seen = 0;
    dp_seen = 0;
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_all();
    rst = 1'b0;

    // one clap held 3 cycles
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    quiet(20);
    chk("s1_tot", 32'(tot0), 1);
    chk("s1_sgl", 32'(sgl0), 1);
    chk("s1_pulse", 32'(sp_seen), 1);

    // second clap inside the window
    clear();
    step(1, 1, 0); quiet(5); step(1, 1, 0);
    quiet(20);
    chk("s2_dbl", 32'(dbl0), 1);
    chk("s2_tot", 32'(tot0), 2);
    chk("s2_pulse", 32'(dp_seen), 1);

    // second clap inside hold-off
    clear();
    step(1, 1, 0); step(0, 1, 0); step(1, 1, 0);
    quiet(20);
    chk("s3_sgl", 32'(sgl0), 1);
    chk("s3_tot", 32'(tot0), 1);

    // second clap on the last window cycle
    clear();
    step(1, 1, 0); quiet(11); step(1, 1, 0);
    quiet(10);
    chk("s4_dbl", 32'(dbl0), 1);
    chk("s4_sgl", 32'(sgl0), 0);

    // sixteen singles: wrap vs saturate
    clear();
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0);
      quiet(14);
    end
    chk("s5_tot_w", 32'(tot0), 0);
    chk("s5_tot_s", 32'(tot1), 15);
    chk("s5_sgl_s", 32'(sgl1), 15);
    chk("s5_pulses", 32'(sp_seen), 16);

    // en low during the event still times out as a single
    clear();
    step(1, 1, 0);
    for (int i = 0; i < 10; i++) step(i == 7, 0, 0);
    quiet(8);
    chk("s6_sgl", 32'(sgl0), 1);

    // async reset mid-window, then clear alongside a clap edge
    clear();
    step(1, 1, 0); quiet(7);
    #2 rst = 1'b1;
    #1;
    m_reset();
    cmp_all();
    #1 rst = 1'b0;
    step(1, 1, 1); step(1, 1, 0); step(1, 1, 0);
    quiet(3);
    chk("s7_tot", 32'(tot0), 0);
    chk("s7_busy", 32'(bz0), 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit c;
      c = ($urandom_range(0, 9) < 2) ? ~clap : clap;
      step(c, $urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
